// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: RAM handshake encoding (shared with the memory
// arbiter) and the responder's internal FSM state.
package cpu_types_pkg;

  localparam int unsigned WORD_W = 32;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACC  = 2'd2
  } resp_state_t;

endpackage

// File: rtl/ram_responder_if.sv
// RAM-side bus between the memory arbiter (master) and the RAM responder (slave).
//   ramREN/ramWEN : read / write request
//   ramaddr       : byte address
//   ramstore      : write data
//   ramload       : read data
//   ramstate      : FREE/BUSY/ACCESS/ERROR handshake
interface ram_responder_if;
  import cpu_types_pkg::*;

  logic              ramREN;
  logic              ramWEN;
  logic [WORD_W-1:0] ramaddr;
  logic [WORD_W-1:0] ramstore;
  logic [WORD_W-1:0] ramload;
  ramstate_t         ramstate;

  modport master (
    output ramREN, ramWEN, ramaddr, ramstore,
    input  ramload, ramstate
  );

  modport slave (
    input  ramREN, ramWEN, ramaddr, ramstore,
    output ramload, ramstate
  );
endinterface

// File: rtl/ram_array.sv
// DEPTH x 32 word array: synchronous write, registered read.
//   clk, rst          : clock, synchronous active-high reset (read register only)
//   we/waddr/wdata    : write port
//   re/raddr/rdata    : registered read port, write-first on same-index collision
module ram_array
  import cpu_types_pkg::*;
#(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH];

  // Storage is never reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // A read landing on the edge that commits a write to the same word sees the new data.
  always_ff @(posedge clk) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= (we && (waddr == raddr)) ? wdata : mem[raddr];
  end

endmodule

// File: rtl/ram_responder.sv
// RAM responder: word-addressed RAM behind the memory arbiter with a
// programmable access latency of LAT wait cycles after request capture.
//   CLK, RST : clock, synchronous active-high reset
//   bus      : slave side of ram_responder_if (request in, ramload/ramstate out)
module ram_responder
  import cpu_types_pkg::*;
#(
  parameter int unsigned LAT   = 2,
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic           CLK,
  input  logic           RST,
  ram_responder_if.slave bus
);

  localparam int unsigned CW       = (LAT == 0) ? 1 : $clog2(LAT + 1);
  localparam bit          HAS_WAIT = (LAT != 0);

  resp_state_t       state, state_d;
  logic [CW-1:0]     cnt, cnt_d;
  logic              lat_op;      // 1 = write
  logic [AW-1:0]     lat_idx;
  logic [WORD_W-1:0] lat_data;

  logic              req, in_range, illegal, legal, same, cap;
  logic [AW-1:0]     cur_idx;
  logic              arr_we, arr_re;
  logic [AW-1:0]     arr_raddr;
  logic [WORD_W-1:0] arr_rdata;

  // Request classification
  always_comb begin
    req      = bus.ramREN | bus.ramWEN;
    in_range = ({2'b00, bus.ramaddr[31:2]} < WORD_W'(DEPTH));
    illegal  = req & ((bus.ramREN & bus.ramWEN) | (bus.ramaddr[1:0] != 2'b00) | ~in_range);
    legal    = req & ~illegal;
    cur_idx  = bus.ramaddr[AW+1:2];
    // Read identity ignores ramstore; write identity includes it.
    same     = legal && (bus.ramWEN == lat_op) && (cur_idx == lat_idx)
               && (!bus.ramWEN || (bus.ramstore == lat_data));
  end

  // Next-state / capture logic
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    cap     = 1'b0;
    case (state)
      IDLE: begin
        if (legal) cap = 1'b1;
      end
      WAIT: begin
        if (same) begin
          cnt_d = cnt - CW'(1);
          if (cnt == CW'(1)) state_d = ACC;
        end else if (legal) begin
          cap = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      ACC: begin
        // Every ACC is a single access; a held request starts a new one.
        if (legal) cap = 1'b1;
        else       state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (cap) begin
      cnt_d   = CW'(LAT);
      state_d = HAS_WAIT ? WAIT : ACC;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      cnt      <= '0;
      lat_op   <= 1'b0;
      lat_idx  <= '0;
      lat_data <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      if (cap) begin
        lat_op   <= bus.ramWEN;
        lat_idx  <= cur_idx;
        lat_data <= bus.ramstore;
      end
    end
  end

  // Read samples on the edge entering ACC; write commits on the edge leaving ACC.
  always_comb begin
    arr_we    = (state == ACC) && lat_op && !RST;
    arr_re    = (state_d == ACC) && !RST && (cap ? !bus.ramWEN : !lat_op);
    arr_raddr = cap ? cur_idx : lat_idx;
  end

  ram_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk   (CLK),
    .rst   (RST),
    .we    (arr_we),
    .waddr (lat_idx),
    .wdata (lat_data),
    .re    (arr_re),
    .raddr (arr_raddr),
    .rdata (arr_rdata)
  );

  assign bus.ramload  = arr_rdata;
  assign bus.ramstate = illegal        ? ERROR  :
                        (state == ACC) ? ACCESS :
                        legal          ? BUSY   : FREE;

endmodule

// File: tb/tb_ram_responder.sv
// Bench for ram_responder: three instances (LAT=2, LAT=0, LAT=3) driven by
// directed steps; expected handshake/data pushed to a scoreboard queue when a
// request is driven and popped as each cycle's output is sampled.
module tb_ram_responder;
  import cpu_types_pkg::*;

  typedef struct {
    int          d;
    ramstate_t   st;
    bit          chk;
    logic [31:0] ld;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst [3];
  logic        ren [3];
  logic        wen [3];
  logic [31:0] addr [3];
  logic [31:0] store [3];
  ramstate_t   st [3];
  logic [31:0] ld [3];

  exp_t        sb [$];
  logic [31:0] model [int];
  string       cur_tag;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  ram_responder_if bus0 ();
  ram_responder_if bus1 ();
  ram_responder_if bus2 ();

  assign bus0.ramREN = ren[0];  assign bus0.ramWEN = wen[0];
  assign bus0.ramaddr = addr[0]; assign bus0.ramstore = store[0];
  assign bus1.ramREN = ren[1];  assign bus1.ramWEN = wen[1];
  assign bus1.ramaddr = addr[1]; assign bus1.ramstore = store[1];
  assign bus2.ramREN = ren[2];  assign bus2.ramWEN = wen[2];
  assign bus2.ramaddr = addr[2]; assign bus2.ramstore = store[2];
  assign st[0] = bus0.ramstate; assign ld[0] = bus0.ramload;
  assign st[1] = bus1.ramstate; assign ld[1] = bus1.ramload;
  assign st[2] = bus2.ramstate; assign ld[2] = bus2.ramload;

  ram_responder #(.LAT(2), .DEPTH(1024)) dut0 (.CLK(clk), .RST(rst[0]), .bus(bus0.slave));
  ram_responder #(.LAT(0), .DEPTH(1024)) dut1 (.CLK(clk), .RST(rst[1]), .bus(bus1.slave));
  ram_responder #(.LAT(3), .DEPTH(1024)) dut2 (.CLK(clk), .RST(rst[2]), .bus(bus2.slave));

  function automatic int key(int d, logic [31:0] a);
    return d * 65536 + int'(a[15:0]);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(int d, bit r, bit w, logic [31:0] a, logic [31:0] s);
    ren[d] = r; wen[d] = w; addr[d] = a; store[d] = s;
  endtask

  task automatic push(int d, ramstate_t s, bit chk, logic [31:0] l);
    exp_t e;
    e.d = d; e.st = s; e.chk = chk; e.ld = l;
    sb.push_back(e);
  endtask

  // Pop one expectation and compare it against this cycle's output.
  task automatic check_next();
    exp_t e;
    @(negedge clk);
    checks++;
    assert (sb.size() != 0) else begin
      errors++;
      $error("FAIL %s scoreboard: got empty queue expected an entry", cur_tag);
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      checks++;
      assert (st[e.d] === e.st) else begin
        errors++;
        $error("FAIL %s ramstate dut%0d: got %0d expected %0d", cur_tag, e.d, st[e.d], e.st);
      end
      if (e.chk) begin
        checks++;
        assert (ld[e.d] === e.ld) else begin
          errors++;
          $error("FAIL %s ramload dut%0d: got %h expected %h", cur_tag, e.d, ld[e.d], e.ld);
        end
      end
    end
  endtask

  // One access; chained means the request is driven in the previous ACC cycle.
  task automatic access(int d, bit w, logic [31:0] a, logic [31:0] s,
                        int nbusy, bit chained, string tag);
    cur_tag = tag;
    if (chained) drive(d, !w, w, a, s);
    tick();
    if (!chained) drive(d, !w, w, a, s);
    for (int i = 0; i < nbusy; i++) push(d, BUSY, 1'b0, '0);
    if (w) begin
      push(d, ACCESS, 1'b0, '0);
      model[key(d, a)] = s;
    end else begin
      push(d, ACCESS, 1'b1, model[key(d, a)]);
    end
    for (int i = 0; i <= nbusy; i++) begin
      if (i > 0) tick();
      check_next();
    end
  endtask

  task automatic release_req(int d);
    cur_tag = "release";
    drive(d, 1'b0, 1'b0, '0, '0);
    tick();
    push(d, FREE, 1'b0, '0);
    check_next();
  endtask

  task automatic err(int d, bit r, bit w, logic [31:0] a, logic [31:0] s, string tag);
    cur_tag = tag;
    tick();
    drive(d, r, w, a, s);
    push(d, ERROR, 1'b0, '0);
    check_next();
  endtask

  // Write a1/s1, then switch to a2/s2 in the second BUSY cycle: count restarts.
  task automatic abort_write(int d, logic [31:0] a1, logic [31:0] s1,
                             logic [31:0] a2, logic [31:0] s2, int lat, string tag);
    cur_tag = tag;
    tick();
    drive(d, 1'b0, 1'b1, a1, s1);
    push(d, BUSY, 1'b0, '0);
    check_next();
    tick();
    drive(d, 1'b0, 1'b1, a2, s2);
    for (int i = 0; i <= lat; i++) push(d, BUSY, 1'b0, '0);
    push(d, ACCESS, 1'b0, '0);
    model[key(d, a2)] = s2;
    for (int i = 0; i <= lat + 1; i++) begin
      if (i > 0) tick();
      check_next();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int d = 0; d < 3; d++) begin
      rst[d] = 1'b1;
      drive(d, 1'b0, 1'b0, '0, '0);
    end
    repeat (3) tick();
    for (int d = 0; d < 3; d++) rst[d] = 1'b0;
    cur_tag = "reset";
    for (int d = 0; d < 3; d++) push(d, FREE, 1'b1, 32'h0);
    for (int d = 0; d < 3; d++) check_next();

    // LAT=2: write/read, illegal requests, read-after-write, reset mid-write
    access(0, 1'b1, 32'h40, 32'hDEADBEEF, 3, 1'b0, "w40");  release_req(0);
    access(0, 1'b0, 32'h40, 32'h0,        3, 1'b0, "r40");  release_req(0);
    access(0, 1'b1, 32'h0,  32'h11111111, 3, 1'b0, "w0");   release_req(0);
    err(0, 1'b1, 1'b1, 32'h40,   32'h0BAD0BAD, "rw_both");
    err(0, 1'b0, 1'b1, 32'h2,    32'h0BAD0002, "misalign");
    err(0, 1'b0, 1'b1, 32'h1000, 32'h0BAD1000, "oob_wr");
    err(0, 1'b1, 1'b0, 32'h1000, 32'h0,        "oob_rd");
    release_req(0);
    access(0, 1'b0, 32'h40, 32'h0, 3, 1'b0, "r40_after_err"); release_req(0);
    access(0, 1'b0, 32'h0,  32'h0, 3, 1'b0, "r0_after_err");  release_req(0);
    access(0, 1'b1, 32'h8,  32'hCAFE0008, 3, 1'b0, "raw_w8");
    access(0, 1'b0, 32'h8,  32'h0,        2, 1'b1, "raw_r8");
    release_req(0);
    access(0, 1'b1, 32'h100, 32'h0100AAAA, 3, 1'b0, "w100"); release_req(0);
    cur_tag = "rst_mid_write";
    tick();
    drive(0, 1'b0, 1'b1, 32'h100, 32'h0100BBBB);
    push(0, BUSY, 1'b0, '0);
    check_next();
    tick();
    push(0, BUSY, 1'b0, '0);
    check_next();
    rst[0] = 1'b1;
    drive(0, 1'b0, 1'b0, '0, '0);
    tick();
    rst[0] = 1'b0;
    push(0, FREE, 1'b1, 32'h0);
    check_next();
    access(0, 1'b0, 32'h100, 32'h0, 3, 1'b0, "r100_post_rst"); release_req(0);

    // LAT=0: back-to-back reads and same-edge read-after-write
    access(1, 1'b1, 32'h0, 32'h22220000, 1, 1'b0, "l0_w0"); release_req(1);
    access(1, 1'b1, 32'h4, 32'h22220004, 1, 1'b0, "l0_w4"); release_req(1);
    access(1, 1'b0, 32'h0, 32'h0, 1, 1'b0, "b2b_r0");
    access(1, 1'b0, 32'h4, 32'h0, 0, 1'b1, "b2b_r4");
    release_req(1);
    access(1, 1'b1, 32'h8, 32'h33330008, 1, 1'b0, "l0_raw_w8");
    access(1, 1'b0, 32'h8, 32'h0,        0, 1'b1, "l0_raw_r8");
    release_req(1);

    // LAT=3: aborts by address change and by write-data change
    access(2, 1'b1, 32'h80, 32'h80808080, 4, 1'b0, "w80"); release_req(2);
    abort_write(2, 32'h80, 32'h5A5A5A5A, 32'h84, 32'h84848484, 3, "abort_addr");
    release_req(2);
    access(2, 1'b0, 32'h80, 32'h0, 4, 1'b0, "r80_kept"); release_req(2);
    access(2, 1'b0, 32'h84, 32'h0, 4, 1'b0, "r84");      release_req(2);
    abort_write(2, 32'hC0, 32'h000000C1, 32'hC0, 32'h000000C2, 3, "abort_data");
    release_req(2);
    access(2, 1'b0, 32'hC0, 32'h0, 4, 1'b0, "rC0"); release_req(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
